// File: rtl/fifo_pkg.sv
// Shared constants and sizing helper for the fifo block.
// Pure declarations: no latency or flow-control behaviour of its own.
package fifo_pkg;

    localparam int FIFO_WL = 4;
    localparam int FIFO_N  = 4;

    // Occupancy counter must hold the value N itself, hence one bit above the index width.
    function automatic int cntr_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/fifo_ctrl.sv
// Occupancy tracking for fifo: accept decisions, write index, EMPTY/FULL flags.
// Latency: push_ok/pop_ok/addr combinational; flags follow the counter one edge after accept.
// Backpressure: push refused when FULL unless paired with a pop; pop refused when EMPTY.
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int N    = FIFO_N,
    parameter int A_WL = cntr_width(N) - 1
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            PUSH,
    input  logic            POP,
    output logic            push_ok,
    output logic            pop_ok,
    output logic [A_WL-1:0] addr,
    output logic            EMPTY,
    output logic            FULL
);

    localparam logic [A_WL:0] N_W = (A_WL + 1)'(N);

    logic [A_WL:0] list_cntr;
    logic [A_WL:0] list_cntr_next;

    assign EMPTY   = (list_cntr == '0);
    assign FULL    = (list_cntr == N_W);
    assign push_ok = PUSH & (~FULL | POP);
    assign pop_ok  = POP & ~EMPTY;

    // With a simultaneous pop the list shifts down first, so the new word lands one slot lower.
    assign addr = list_cntr[A_WL-1:0] - A_WL'(pop_ok);

    always_comb begin
        list_cntr_next = list_cntr;
        case ({push_ok, pop_ok})
            2'b10:   list_cntr_next = list_cntr + 1'b1;
            2'b01:   list_cntr_next = list_cntr - 1'b1;
            default: list_cntr_next = list_cntr;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            list_cntr <= '0;
        end else begin
            list_cntr <= list_cntr_next;
        end
    end

endmodule

// File: rtl/fifo.sv
// Shift-register FIFO, oldest word on head, popped word registered on dout; FIFO_ERR_FLAGS_EN adds sticky OVERFLOW/UNDERFLOW.
// Latency: dout updates on the accepting edge; head/EMPTY/FULL reflect new state the cycle after.
// Backpressure: full push without pop is dropped; pop when empty is ignored and dout holds.
module fifo
    import fifo_pkg::*;
#(
    parameter int WL   = FIFO_WL,
    parameter int N    = FIFO_N,
    parameter int A_WL = cntr_width(N) - 1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          PUSH,
    input  logic          POP,
    input  logic [WL-1:0] din,
    output logic          EMPTY,
    output logic          FULL,
    output logic [WL-1:0] head,
    output logic [WL-1:0] dout
`ifdef FIFO_ERR_FLAGS_EN
    ,
    output logic          OVERFLOW,
    output logic          UNDERFLOW
`endif
);

    logic            push_ok;
    logic            pop_ok;
    logic [A_WL-1:0] addr;
    logic [WL-1:0]   mem [N];

    fifo_ctrl #(
        .N    (N),
        .A_WL (A_WL)
    ) u_ctrl (
        .CLK     (CLK),
        .RST     (RST),
        .PUSH    (PUSH),
        .POP     (POP),
        .push_ok (push_ok),
        .pop_ok  (pop_ok),
        .addr    (addr),
        .EMPTY   (EMPTY),
        .FULL    (FULL)
    );

    assign head = EMPTY ? '0 : mem[0];

    // Slots above the occupancy are kept at zero, so shifting a zero into the top
    // clears the vacated slot exactly as clearing mem[list_cntr-1] would.
    always_ff @(posedge CLK) begin
        if (RST) begin
            dout <= '0;
            for (int i = 0; i < N; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (pop_ok) begin
                dout <= mem[0];
                for (int i = 0; i < N - 1; i++) begin
                    mem[i] <= mem[i+1];
                end
                mem[N-1] <= '0;
            end
            if (push_ok) begin
                mem[addr] <= din;
            end
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            OVERFLOW  <= 1'b0;
            UNDERFLOW <= 1'b0;
        end else begin
            if (PUSH & FULL & ~POP) OVERFLOW  <= 1'b1;
            if (POP & EMPTY)        UNDERFLOW <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo.sv
// Bench for fifo: directed scenarios then random traffic, all checked against a queue model.
// Latency: model advances on each rising edge, outputs sampled 1 time unit later.
module tb_fifo;

    localparam int WL = 4;
    localparam int N  = 4;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          PUSH = 1'b0;
    logic          POP = 1'b0;
    logic [WL-1:0] din = '0;
    logic          EMPTY;
    logic          FULL;
    logic [WL-1:0] head;
    logic [WL-1:0] dout;
`ifdef FIFO_ERR_FLAGS_EN
    logic          OVERFLOW;
    logic          UNDERFLOW;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [WL-1:0] mq [$];
    logic [WL-1:0] m_dout = '0;
    logic          m_ovf  = 1'b0;
    logic          m_unf  = 1'b0;

    fifo dut (
        .CLK   (CLK),
        .RST   (RST),
        .PUSH  (PUSH),
        .POP   (POP),
        .din   (din),
        .EMPTY (EMPTY),
        .FULL  (FULL),
        .head  (head),
        .dout  (dout)
`ifdef FIFO_ERR_FLAGS_EN
        ,
        .OVERFLOW  (OVERFLOW),
        .UNDERFLOW (UNDERFLOW)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        logic [WL-1:0] exp_head;
        exp_head = (mq.size() == 0) ? '0 : mq[0];
        chk({tag, ".EMPTY"}, 32'(EMPTY), 32'(mq.size() == 0));
        chk({tag, ".FULL"},  32'(FULL),  32'(mq.size() == N));
        chk({tag, ".head"},  32'(head),  32'(exp_head));
        chk({tag, ".dout"},  32'(dout),  32'(m_dout));
`ifdef FIFO_ERR_FLAGS_EN
        chk({tag, ".OVERFLOW"},  32'(OVERFLOW),  32'(m_ovf));
        chk({tag, ".UNDERFLOW"}, 32'(UNDERFLOW), 32'(m_unf));
`endif
    endtask

    // One clock of traffic; the model applies the accept rules to its pre-edge state.
    task automatic step(input string tag, input logic p, input logic q, input logic [WL-1:0] d);
        bit was_full, was_empty;
        @(negedge CLK);
        PUSH = p; POP = q; din = d;
        @(posedge CLK);
        was_full  = (mq.size() == N);
        was_empty = (mq.size() == 0);
        if (p && was_full && !q) m_ovf = 1'b1;
        if (q && was_empty)      m_unf = 1'b1;
        if (q && !was_empty) m_dout = mq.pop_front();
        if (p && (!was_full || q)) mq.push_back(d);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge CLK);
        RST = 1'b1; PUSH = 1'b0; POP = 1'b0;
        repeat (cycles) @(posedge CLK);
        mq.delete();
        m_dout = '0; m_ovf = 1'b0; m_unf = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        check_all("reset");
    endtask

    initial begin
        // Power-on reset and basic push/pop ordering
        do_reset(2);
        chk("reset.head_zero", 32'(head), 32'h0);
        step("push3", 1, 0, 4'd3);
        step("push4", 1, 0, 4'd4);
        step("pop1", 0, 1, 4'd0);
        chk("pop1.dout_is_3", 32'(dout), 32'd3);
        chk("pop1.head_is_4", 32'(head), 32'd4);

        // Fill, then a refused push
        step("push7", 1, 0, 4'd7);
        step("push6", 1, 0, 4'd6);
        step("push2", 1, 0, 4'd2);
        chk("fill.FULL", 32'(FULL), 32'd1);
        step("push1_full", 1, 0, 4'd1);

        // Drain past empty; the fifth pop is ignored
        for (int i = 0; i < 5; i++) step("drain", 0, 1, 4'd0);
        chk("drain.dout_holds_2", 32'(dout), 32'd2);
        chk("drain.EMPTY", 32'(EMPTY), 32'd1);

        // Simultaneous push+pop at full, then drain
        step("f1", 1, 0, 4'd1);
        step("f2", 1, 0, 4'd2);
        step("f3", 1, 0, 4'd3);
        step("f4", 1, 0, 4'd4);
        step("pp_full", 1, 1, 4'd9);
        chk("pp_full.dout_is_1", 32'(dout), 32'd1);
        chk("pp_full.head_is_2", 32'(head), 32'd2);
        for (int i = 0; i < 4; i++) step("pp_drain", 0, 1, 4'd0);
        chk("pp_drain.last_is_9", 32'(dout), 32'd9);

        // Simultaneous push+pop when empty: only the push takes effect
        step("pp_empty", 1, 1, 4'd5);
        chk("pp_empty.head_is_5", 32'(head), 32'd5);
        chk("pp_empty.dout_holds_9", 32'(dout), 32'd9);

        // Reset with contents, then pop must be ignored
        step("m1", 1, 0, 4'd8);
        step("m2", 1, 0, 4'd10);
        do_reset(1);
        step("pop_after_rst", 0, 1, 4'd0);
        chk("pop_after_rst.dout_zero", 32'(dout), 32'd0);

        // Random traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) < 2) begin
                do_reset(1);
            end else begin
                step("rand", 1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 50),
                     WL'($urandom_range(0, 15)));
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fifo.md
Name: fifo

Overview:
- Synchronous first-in/first-out queue of N words, each WL bits wide, with a single clock.
- Exposes the oldest entry combinationally on head and returns the popped word registered on dout.
- EMPTY and FULL status flags are derived from an occupancy counter.
- Generic buffering block placed between a producer issuing PUSH and a consumer issuing POP.

Parameters:
- WL, 4, data word width in bits.
- N, 4, depth in words (any value >= 2; power of two not required).
- A_WL, $clog2(N), address width used to index storage; the occupancy counter is A_WL+1 bits.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  synchronous active-high reset.
- PUSH  input  1  write request; din is sampled on the same edge.
- POP  input  1  read request.
- din  input  WL  write data.
- EMPTY  output  1  high when occupancy == 0.
- FULL  output  1  high when occupancy == N.
- head  output  WL  oldest stored word, combinational from storage; 0 when EMPTY.
- dout  output  WL  registered word removed by the most recent accepted pop.

Behaviour:
- Storage is a shift-register list mem[0..N-1]:
  - mem[0] is always the oldest entry.
  - list_cntr (A_WL+1 bits) holds the occupancy.
  - list_cntr_next is its combinational next value.
  - addr is the write index.
- Reset, while RST=1 at a rising edge:
  - list_cntr=0, all mem=0, dout=0.
  - Therefore EMPTY=1, FULL=0, head=0.
  - RST has priority over PUSH/POP.
  - Reset mid-operation discards all contents.
- Accepted operations:
  - push_ok = PUSH & (~FULL | POP).
  - pop_ok = POP & ~EMPTY.
- Push only (push_ok, !pop_ok):
  - mem[list_cntr] <= din.
  - list_cntr += 1.
- Pop only (pop_ok, !push_ok):
  - dout <= mem[0].
  - mem[i] <= mem[i+1] for i < N-1.
  - mem[list_cntr-1] <= 0.
  - list_cntr -= 1.
- Push and pop together:
  - dout <= mem[0].
  - The list shifts down.
  - din is written at index list_cntr-1.
  - list_cntr is unchanged.
  - This is allowed when FULL (no loss).
- Push while EMPTY with POP also high: the pop is ignored and the push proceeds normally.
- Push when FULL without POP: ignored. The word is dropped and state is unchanged.
- Pop when EMPTY: ignored, and dout holds its previous value.
- Latency and timing:
  - EMPTY, FULL and head reflect the new state in the cycle after the accepting edge.
  - dout updates on the same edge that accepts the pop.
- The counter never exceeds N or goes below 0.

Optional Feature:
- Macro FIFO_ERR_FLAGS_EN.
- When defined, adds two outputs, each 1 bit:
  - OVERFLOW, set on a rejected push (PUSH & FULL & ~POP).
  - UNDERFLOW, set on a rejected pop (POP & EMPTY).
- Both flags are sticky and cleared only by RST.
- When undefined, these ports and their logic do not exist, and behaviour is otherwise identical.

Decomposition:
- Shared package fifo_pkg holds:
  - default constants FIFO_WL=4 and FIFO_N=4.
  - a function computing the counter width ($clog2(N)+1).
- One optional sub-module, fifo_ctrl:
  - computes push_ok, pop_ok, list_cntr_next and addr, plus EMPTY/FULL.
  - the storage shift array stays in the top module.

Test Plan:
- Reset: hold RST for 2 cycles -> EMPTY=1, FULL=0, head=0, dout=0, list_cntr=0.
- Push 3, then push 4, then a single pop -> after the pop, dout=3, head=4, list_cntr=1, EMPTY=0.
- Fill to full:
  - From 1 entry (4), push 7, 6, 2 -> list_cntr=4, FULL=1.
  - Then push 1 -> rejected, list_cntr stays 4, and 1 is never popped.
- Drain past empty:
  - Five consecutive pops -> dout sequence 4, 7, 6, 2.
  - EMPTY=1 after the 4th pop.
  - The 5th pop is ignored, leaving dout=2 and list_cntr=0.
- Simultaneous push+pop:
  - When FULL holding 1, 2, 3, 4, push 9 with pop -> dout=1, head=2, FULL stays 1, and later pops give 2, 3, 4, 9.
  - When EMPTY, push 5 with pop -> list_cntr=1, head=5, dout unchanged.
- Mid-operation reset: with 3 entries, assert RST for 1 cycle -> EMPTY=1, head=0, dout=0, and a subsequent pop is ignored.
